rej_uniform_sampler: RTL and testbench

//  Downstream consumer of the Keccak squeeze output in ExpandA (SHAKE128 mode).

---
 rtl/rej_uniform_sampler.sv | 92 +++++++++
 tb/tb_rej_uniform_sampler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rej_uniform_sampler.sv
// rej_uniform_sampler: rejection-samples 23-bit coefficients < Q from SHAKE128 squeeze blocks.
// Define REJ_SAMPLER_STATS_EN to add the rej_cnt rejected-candidate counter output.
module rej_uniform_sampler #(
   parameter int N_COEF       = 256,
   parameter int Q            = 8380417,
   parameter int CAND_PER_BLK = 56
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1343:0] blk_in,
   input  logic          blk_valid,
   output logic          blk_ack,
   output logic [22:0]   coef_out,
   output logic [7:0]    coef_idx,
   output logic          coef_valid,
   input  logic          coef_ready,
   output logic          busy,
   output logic          done
`ifdef REJ_SAMPLER_STATS_EN
   ,
   output logic [15:0]   rej_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, WAIT, SCAN, DRAIN} state_t;
   state_t state;
   logic [1343:0] blk;
   logic [5:0] j;
   logic [8:0] acc_cnt;
   logic [22:0] t;
   logic acc_ok, slot_free;
   // The block shifts down 24 bits per consumed candidate, so the current one is always at the bottom.
   assign t = blk[22:0];
   assign acc_ok = t < 23'(Q);
   assign slot_free = ~coef_valid | coef_ready;
   assign busy = state != IDLE;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         blk <= '0;
         j <= '0;
         acc_cnt <= '0;
         blk_ack <= 1'b0;
         coef_valid <= 1'b0;
         coef_out <= '0;
         coef_idx <= '0;
         done <= 1'b0;
`ifdef REJ_SAMPLER_STATS_EN
         rej_cnt <= '0;
`endif
      end else begin
         blk_ack <= 1'b0;
         done <= 1'b0;
         if (coef_valid & coef_ready) coef_valid <= 1'b0;
         case (state)
            IDLE: if (start) begin
               acc_cnt <= '0;
               state <= WAIT;
`ifdef REJ_SAMPLER_STATS_EN
               rej_cnt <= '0;
`endif
            end
            WAIT: if (blk_valid) begin
               blk <= blk_in;
               blk_ack <= 1'b1;
               j <= '0;
               state <= SCAN;
            end
            SCAN: if (slot_free) begin
               blk <= blk >> 24;
               j <= j + 6'd1;
               if (acc_ok) begin
                  coef_out <= t;
                  coef_idx <= acc_cnt[7:0];
                  coef_valid <= 1'b1;
                  acc_cnt <= acc_cnt + 9'd1;
               end
`ifdef REJ_SAMPLER_STATS_EN
               else if (rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
`endif
               if (acc_ok && acc_cnt == 9'(N_COEF - 1)) state <= DRAIN;
               else if (j == 6'(CAND_PER_BLK - 1)) state <= WAIT;
            end
            DRAIN: if (coef_valid & coef_ready) begin
               done <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_rej_uniform_sampler.sv
// tb_rej_uniform_sampler: directed tests with a queue-based reference of accepted coefficients.
module tb_rej_uniform_sampler;
   localparam int Q = 8380417;
   logic clk = 0, reset = 1, start = 0, blk_valid = 0, coef_ready = 1;
   logic [1343:0] blk_in = '0;
   logic blk_ack, coef_valid, busy, done;
   logic [22:0] coef_out;
   logic [7:0] coef_idx;
`ifdef REJ_SAMPLER_STATS_EN
   logic [15:0] rej_cnt;
`endif
   rej_uniform_sampler dut (
      .clk(clk), .reset(reset), .start(start), .blk_in(blk_in), .blk_valid(blk_valid),
      .blk_ack(blk_ack), .coef_out(coef_out), .coef_idx(coef_idx), .coef_valid(coef_valid),
      .coef_ready(coef_ready), .busy(busy), .done(done)
`ifdef REJ_SAMPLER_STATS_EN
      , .rej_cnt(rej_cnt)
`endif
   );
   always #5 clk = ~clk;

   int n_pass = 0, n_chk = 0;
   logic [1343:0] feed[$];
   int exp_coef[$];
   int model_n, model_rej, hs_cnt, acks, done_cnt, cyc, nack, first_valid_cyc, rmode;
   int ack_cyc[8];
   logic [22:0] got[4];
   logic pv, pr;
   logic [22:0] pc;
   logic [7:0] pi;

   task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
      n_chk++;
      if (g === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, g, e);
   endtask

   task automatic clear_model();
      feed.delete();
      exp_coef.delete();
      model_n = 0; model_rej = 0; hs_cnt = 0; acks = 0; nack = 0;
      first_valid_cyc = -1; pv = 0; pr = 1;
   endtask

   // Reference: every acked block yields its in-range candidates, in order, until 256 are owed.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (pv && !pr) begin
         chk("stall_valid", coef_valid, 1);
         chk("stall_coef", coef_out, pc);
         chk("stall_idx", coef_idx, pi);
      end
      if (blk_ack) begin
         if (nack < 8) ack_cyc[nack] = cyc;
         nack++;
         acks++;
         if (feed.size() == 0) chk("ack_without_block", 1, 0);
         else begin
            logic [1343:0] b;
            b = feed.pop_front();
            for (int k = 0; k < 56; k++) begin
               int v;
               v = int'(b[24*k +: 8]) + 256 * int'(b[24*k+8 +: 8]) + 65536 * int'(b[24*k+16 +: 7]);
               if (model_n < 256) begin
                  if (v < Q) begin exp_coef.push_back(v); model_n++; end
                  else model_rej++;
               end
            end
         end
      end
      coef_ready = rmode != 0 ? ~coef_ready : 1'b1;
      blk_valid = feed.size() > 0;
      blk_in = feed.size() > 0 ? feed[0] : '0;
      if (coef_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (coef_valid && coef_ready) begin
         chk("hs_idx", coef_idx, hs_cnt[7:0]);
         if (exp_coef.size() == 0) chk("hs_unexpected", coef_out, 32'hFFFFFFFF);
         else chk("hs_coef", coef_out, exp_coef.pop_front());
         if (hs_cnt < 4) got[hs_cnt] = coef_out;
         hs_cnt++;
      end
      if (done) begin
         done_cnt++;
         chk("done_after_last", hs_cnt, 256);
         chk("done_busy", busy, 0);
`ifdef REJ_SAMPLER_STATS_EN
         chk("done_rej_cnt", rej_cnt, model_rej);
`endif
      end
      pv = coef_valid; pr = coef_ready; pc = coef_out; pi = coef_idx;
   end

   task automatic go(input int n_ack);
      int d0, n;
      d0 = done_cnt; n = 0;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      while (done_cnt == d0 && n < 5000) begin @(negedge clk); n++; end
      chk("done_seen", done_cnt - d0, 1);
      chk("handshakes", hs_cnt, 256);
      chk("model_drained", exp_coef.size(), 0);
      chk("ack_count", acks, n_ack);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      logic [1343:0] b;
      clear_model();
      rmode = 0; done_cnt = 0; cyc = 0;
      repeat (3) @(negedge clk);
      chk("rst_ack", blk_ack, 0);
      chk("rst_valid", coef_valid, 0);
      chk("rst_coef", coef_out, 0);
      chk("rst_idx", coef_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 0;
      // All-zero blocks: 4 full blocks plus 32 candidates of a fifth.
      @(negedge clk) clear_model();
      repeat (5) feed.push_back('0);
      go(5);
      chk("latency", first_valid_cyc - ack_cyc[0], 1);
      // Boundary candidates: Q rejected, Q-1 accepted, bit 23 masked.
      @(negedge clk) clear_model();
      b = '0;
      b[23:0] = 24'h7FE001;
      b[47:24] = 24'h7FE000;
      b[71:48] = 24'h800005;
      repeat (5) feed.push_back(b);
      go(5);
      chk("pin_q_minus_1", got[0], 23'h7FE000);
      chk("pin_bit23_masked", got[1], 23'd5);
      chk("pin_zero", got[2], 23'd0);
      // Whole block rejected: 56 SCAN cycles, then a fresh ack.
      @(negedge clk) clear_model();
      b = {168{8'hFF}};
      feed.push_back(b);
      repeat (5) feed.push_back('0);
      go(6);
      chk("reject_blk_gap", ack_cyc[1] - ack_cyc[0], 57);
      chk("reject_no_valid", first_valid_cyc - ack_cyc[1], 1);
      // Toggled ready with a stray start mid-run that must be ignored.
      @(negedge clk) clear_model();
      rmode = 1;
      repeat (5) feed.push_back('0);
      fork
         go(5);
         begin
            for (int n = 0; n < 3000 && hs_cnt < 50; n++) @(negedge clk);
            start = 1;
            @(negedge clk) start = 0;
         end
      join
      rmode = 0;
      // Reset mid-run abandons the polynomial, then a clean restart.
      @(negedge clk) clear_model();
      repeat (5) feed.push_back('0);
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      for (int n = 0; n < 3000 && hs_cnt < 100; n++) @(negedge clk);
      chk("reached_100", hs_cnt >= 100, 1);
      reset = 1;
      @(posedge clk) #1;
      chk("mid_rst_valid", coef_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk) reset = 0;
      clear_model();
      repeat (5) feed.push_back('0);
      go(5);
`ifdef REJ_SAMPLER_STATS_EN
      @(negedge clk) clear_model();
      b = '0;
      for (int k = 0; k < 10; k++) b[24*k +: 24] = 24'h7FFFFF;
      feed.push_back(b);
      repeat (4) feed.push_back('0);
      go(5);
      chk("rej_cnt_10", rej_cnt, 10);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
